// File: rtl/insn_fetcher.sv
// Instruction fetcher with a BCD instruction pointer, a one-cycle request/guard handshake and jump loads.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT timeout with a sticky Error flag.
module insn_fetcher #(
    parameter int IP_DEKATRON_NUM = 6,
    parameter int DEKATRON_WIDTH  = 4,
    parameter int INSN_WIDTH      = 4
) (
    input  logic                                      Clk,
    input  logic                                      Rst,
    input  logic                                      Enable,
    input  logic                                      Dir,
    input  logic                                      Load,
    input  logic [IP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] LoadAddr,
    output logic                                      InsnValid,
    input  logic                                      InsnAck,
    output logic [INSN_WIDTH-1:0]                     Insn,
    output logic [IP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] Ip,
    output logic                                      MemRequest,
    input  logic                                      MemReady,
    input  logic [INSN_WIDTH-1:0]                     MemInsn,
    output logic                                      Error
);

    localparam int IP_W = IP_DEKATRON_NUM * DEKATRON_WIDTH;

    typedef enum logic [2:0] {IDLE, REQ, GUARD, WAIT, VALID} state_t;

    state_t                state, state_nxt;
    logic [IP_W-1:0]       ip_q, ip_nxt;
    logic [IP_W-1:0]       pend_addr, pend_addr_nxt;
    logic                  pend_vld, pend_vld_nxt;
    logic [INSN_WIDTH-1:0] insn_q, insn_nxt;
`ifdef FETCH_TIMEOUT_EN
    logic [3:0]            tmo_cnt, tmo_cnt_nxt;
    logic                  err_q, err_nxt;
`endif

    // Ripple a +1/-1 through the BCD digits; a digit at 9 (or above) wraps up to 0, a 0 wraps down to 9.
    function automatic logic [IP_W-1:0] bcd_step(input logic [IP_W-1:0] v, input logic dec);
        logic [IP_W-1:0]           r;
        logic [DEKATRON_WIDTH-1:0] d;
        logic                      c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < IP_DEKATRON_NUM; i++) begin
            d = v[i*DEKATRON_WIDTH +: DEKATRON_WIDTH];
            if (c) begin
                if (dec) begin
                    if (d == DEKATRON_WIDTH'(0)) d = DEKATRON_WIDTH'(9);
                    else begin
                        d = d - DEKATRON_WIDTH'(1);
                        c = 1'b0;
                    end
                end else begin
                    if (d >= DEKATRON_WIDTH'(9)) d = DEKATRON_WIDTH'(0);
                    else begin
                        d = d + DEKATRON_WIDTH'(1);
                        c = 1'b0;
                    end
                end
            end
            r[i*DEKATRON_WIDTH +: DEKATRON_WIDTH] = d;
        end
        return r;
    endfunction

    always_comb begin
        state_nxt     = state;
        ip_nxt        = ip_q;
        insn_nxt      = insn_q;
        pend_vld_nxt  = pend_vld;
        pend_addr_nxt = pend_addr;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_nxt   = tmo_cnt;
        err_nxt       = Load ? 1'b0 : err_q;
`endif
        case (state)
            IDLE: begin
                if (Load)        ip_nxt    = LoadAddr;
                else if (Enable) state_nxt = REQ;
            end
            REQ, GUARD: begin
                // Ip must not move while the memory is addressed, so jumps are parked until the fetch ends.
                if (Load) begin
                    pend_vld_nxt  = 1'b1;
                    pend_addr_nxt = LoadAddr;
                end
                state_nxt = (state == REQ) ? GUARD : WAIT;
`ifdef FETCH_TIMEOUT_EN
                tmo_cnt_nxt = 4'd0;
`endif
            end
            WAIT: begin
                if (Load) begin
                    pend_vld_nxt  = 1'b1;
                    pend_addr_nxt = LoadAddr;
                end
`ifdef FETCH_TIMEOUT_EN
                if (!MemReady) begin
                    if (tmo_cnt == 4'd14) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 4'd1;
                    end
                end
`endif
                if (MemReady) begin
                    if (Load || pend_vld) state_nxt = IDLE;
                    else begin
                        insn_nxt  = MemInsn;
                        state_nxt = VALID;
                    end
                end
                // A parked jump takes effect however the wait ends; the fetched word is dropped.
                if (state_nxt == IDLE && (Load || pend_vld)) begin
                    ip_nxt       = Load ? LoadAddr : pend_addr;
                    pend_vld_nxt = 1'b0;
                end
            end
            VALID: begin
                if (Load) begin
                    ip_nxt    = LoadAddr;
                    state_nxt = IDLE;
                end else if (InsnAck) begin
                    ip_nxt    = bcd_step(ip_q, Dir);
                    state_nxt = Enable ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            ip_q      <= '0;
            insn_q    <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt   <= 4'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ip_q      <= ip_nxt;
            insn_q    <= insn_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_addr <= pend_addr_nxt;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt   <= tmo_cnt_nxt;
            err_q     <= err_nxt;
`endif
        end
    end

    assign InsnValid  = (state == VALID);
    assign MemRequest = (state == REQ);
    assign Ip         = ip_q;
    assign Insn       = insn_q;
`ifdef FETCH_TIMEOUT_EN
    assign Error      = err_q;
`else
    assign Error      = 1'b0;
`endif

endmodule

// File: tb/tb_insn_fetcher.sv
// Bench for insn_fetcher: directed steps plus randomized fetches against a decimal-integer model of Ip.
module tb_insn_fetcher;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Enable;
    logic        Dir;
    logic        Load;
    logic [23:0] LoadAddr;
    logic        InsnValid;
    logic        InsnAck;
    logic [3:0]  Insn;
    logic [23:0] Ip;
    logic        MemRequest;
    logic        MemReady;
    logic [3:0]  MemInsn;
    logic        Error;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_ip;
    logic [3:0]  m_insn;
    logic        m_err;

    insn_fetcher dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Dir(Dir), .Load(Load), .LoadAddr(LoadAddr),
        .InsnValid(InsnValid), .InsnAck(InsnAck), .Insn(Insn), .Ip(Ip),
        .MemRequest(MemRequest), .MemReady(MemReady), .MemInsn(MemInsn), .Error(Error)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int stepped(input int v, input logic dec);
        return dec ? (v + 999999) % 1000000 : (v + 1) % 1000000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_ip(input string tag);
        check(tag, 32'(Ip), 32'(to_bcd(m_ip)));
    endtask

    task automatic do_load(input int addr);
        Load = 1'b1;
        LoadAddr = to_bcd(addr);
        tick;
        Load = 1'b0;
        m_ip = addr;
        m_err = 1'b0;
        check_ip("load_ip");
        check("load_nv", 32'(InsnValid), 32'd0);
        check("load_err", 32'(Error), 32'(m_err));
    endtask

    // From IDLE (or already in REQ) to VALID, with a stale MemReady during GUARD.
    task automatic run_to_valid(input logic [3:0] data, input int delay, input bit in_req);
        if (!in_req) begin
            Enable = 1'b1;
            tick;
        end
        check("req_pulse", 32'(MemRequest), 32'd1);
        check_ip("req_ip");
        Enable = 1'b0;
        MemReady = 1'($urandom_range(0, 1));
        MemInsn = 4'($urandom);
        tick;
        check("guard_req", 32'(MemRequest), 32'd0);
        check("guard_nv", 32'(InsnValid), 32'd0);
        MemReady = 1'b1;
        MemInsn = ~data;
        tick;
        for (int k = 0; k < delay; k++) begin
            check_ip("wait_ip");
            MemReady = 1'b0;
            MemInsn = 4'($urandom);
            tick;
        end
        check("wait_nv", 32'(InsnValid), 32'd0);
        check_ip("wait_ip_end");
        MemReady = 1'b1;
        MemInsn = data;
        tick;
        MemReady = 1'($urandom_range(0, 1));
        MemInsn = 4'($urandom);
        m_insn = data;
        check("valid_flag", 32'(InsnValid), 32'd1);
        check("valid_insn", 32'(Insn), 32'(m_insn));
        check_ip("valid_ip");
        check("valid_err", 32'(Error), 32'(m_err));
    endtask

    task automatic ack(input logic dir, input logic en);
        InsnAck = 1'b1;
        Dir = dir;
        Enable = en;
        tick;
        InsnAck = 1'b0;
        Enable = 1'b0;
        m_ip = stepped(m_ip, dir);
        check_ip("ack_ip");
        check("ack_nv", 32'(InsnValid), 32'd0);
        check("ack_req", 32'(MemRequest), 32'(en));
    endtask

    initial begin
        bit   in_req;
        int   addr;
        logic d;
        logic en;

        Rst = 1'b1; Enable = 1'b0; Dir = 1'b0; Load = 1'b0; LoadAddr = '0;
        InsnAck = 1'b0; MemReady = 1'b0; MemInsn = '0;
        m_ip = 0; m_insn = '0; m_err = 1'b0;
        #1;
        check("rst_ip", 32'(Ip), 32'd0);
        check("rst_insn", 32'(Insn), 32'd0);
        check("rst_nv", 32'(InsnValid), 32'd0);
        check("rst_req", 32'(MemRequest), 32'd0);
        check("rst_err", 32'(Error), 32'd0);
        tick;
        Rst = 1'b0;
        tick;
        tick;
        check("idle_req", 32'(MemRequest), 32'd0);

        // Basic fetch at Ip 0, data 5, stale ready in GUARD
        run_to_valid(4'h5, 0, 1'b0);
        for (int h = 0; h < 2; h++) begin
            MemInsn = 4'($urandom);
            tick;
            check("hold_valid", 32'(InsnValid), 32'd1);
            check("hold_insn", 32'(Insn), 32'(m_insn));
        end
        ack(1'b0, 1'b0);

        // BCD carry / wrap boundaries
        do_load(9);
        run_to_valid(4'h3, 1, 1'b0);
        ack(1'b0, 1'b0);
        check("carry_000010", 32'(Ip), 32'h000010);
        do_load(999999);
        run_to_valid(4'hC, 2, 1'b0);
        ack(1'b0, 1'b0);
        check("wrap_up", 32'(Ip), 32'h000000);
        run_to_valid(4'h6, 0, 1'b0);
        ack(1'b1, 1'b0);
        check("wrap_down", 32'(Ip), 32'h999999);

        // Randomized fetches, with back-to-back starts when Enable is high at ack
        in_req = 1'b0;
        for (int it = 0; it < 10; it++) begin
            if (!in_req) begin
                addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) * 999999
                                                   : int'($urandom_range(0, 999999));
                do_load(addr);
            end
            run_to_valid(4'($urandom), int'($urandom_range(0, 6)), in_req);
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                Enable = 1'($urandom_range(0, 1));
                MemInsn = 4'($urandom);
                tick;
                check("rnd_hold_insn", 32'(Insn), 32'(m_insn));
                check("rnd_hold_valid", 32'(InsnValid), 32'd1);
            end
            d = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1));
            ack(d, en);
            in_req = en;
        end
        if (in_req) begin
            run_to_valid(4'h1, 0, 1'b1);
            ack(1'b0, 1'b0);
        end

        // Jumps parked during REQ and GUARD (second overwrites first), applied when WAIT ends
        do_load(123456);
        Enable = 1'b1;
        tick;
        Enable = 1'b0;
        Load = 1'b1;
        LoadAddr = to_bcd(111111);
        tick;
        check_ip("pend_guard_ip");
        LoadAddr = to_bcd(999900);
        MemReady = 1'b1;
        tick;
        Load = 1'b0;
        check_ip("pend_wait_ip");
        MemInsn = 4'h7;
        tick;
        m_ip = 999900;
        check("pend_ip", 32'(Ip), 32'h999900);
        check("pend_nv", 32'(InsnValid), 32'd0);
        check("pend_insn", 32'(Insn), 32'(m_insn));
        tick;
        check("pend_idle_nv", 32'(InsnValid), 32'd0);
        check("pend_idle_req", 32'(MemRequest), 32'd0);

        // Jump arriving in WAIT while memory is not ready
        do_load(222);
        Enable = 1'b1;
        tick;
        Enable = 1'b0;
        tick;
        MemReady = 1'b0;
        tick;
        Load = 1'b1;
        LoadAddr = to_bcd(777);
        tick;
        Load = 1'b0;
        check_ip("wait_load_hold_ip");
        check("wait_load_nv", 32'(InsnValid), 32'd0);
        MemReady = 1'b1;
        tick;
        m_ip = 777;
        check_ip("wait_load_ip");
        check("wait_load_nv2", 32'(InsnValid), 32'd0);

        // Load and ack together in VALID: Load wins
        do_load(123);
        run_to_valid(4'h9, 1, 1'b0);
        Load = 1'b1;
        LoadAddr = to_bcd(500);
        InsnAck = 1'b1;
        Enable = 1'b1;
        tick;
        Load = 1'b0;
        InsnAck = 1'b0;
        Enable = 1'b0;
        m_ip = 500;
        check("la_ip", 32'(Ip), 32'h000500);
        check("la_nv", 32'(InsnValid), 32'd0);
        check("la_req", 32'(MemRequest), 32'd0);
        tick;

        // Reset in the middle of a fetch
        Enable = 1'b1;
        tick;
        Enable = 1'b0;
        tick;
        MemReady = 1'b1;
        MemInsn = 4'h9;
        tick;
        Rst = 1'b1;
        #2;
        check("mid_rst_ip", 32'(Ip), 32'd0);
        check("mid_rst_nv", 32'(InsnValid), 32'd0);
        check("mid_rst_insn", 32'(Insn), 32'd0);
        check("mid_rst_req", 32'(MemRequest), 32'd0);
        tick;
        Rst = 1'b0;
        m_ip = 0; m_insn = '0; m_err = 1'b0;
        tick;
        tick;
        check("post_rst_nv", 32'(InsnValid), 32'd0);
        check("post_rst_req", 32'(MemRequest), 32'd0);
        check("post_rst_insn", 32'(Insn), 32'd0);
        Enable = 1'b1;
        #1;
        check("post_rst_noreq", 32'(MemRequest), 32'd0);
        tick;
        run_to_valid(4'hE, 0, 1'b1);
        ack(1'b1, 1'b0);

        // Memory never ready
        do_load(42);
        Enable = 1'b1;
        tick;
        Enable = 1'b0;
        MemReady = 1'b0;
        tick;
        tick;
`ifdef FETCH_TIMEOUT_EN
        for (int k = 0; k < 14; k++) begin
            check("tmo_nv", 32'(InsnValid), 32'd0);
            check("tmo_err_early", 32'(Error), 32'd0);
            tick;
        end
        check("tmo_err_15", 32'(Error), 32'd0);
        tick;
        m_err = 1'b1;
        check("tmo_err", 32'(Error), 32'd1);
        check("tmo_nv_end", 32'(InsnValid), 32'd0);
        check_ip("tmo_ip");
        Enable = 1'b1;
        tick;
        run_to_valid(4'h2, 0, 1'b1);
        ack(1'b0, 1'b0);
        check("tmo_sticky", 32'(Error), 32'd1);
        do_load(0);
`else
        for (int k = 0; k < 20; k++) begin
            check("nto_err", 32'(Error), 32'd0);
            check("nto_nv", 32'(InsnValid), 32'd0);
            check("nto_req", 32'(MemRequest), 32'd0);
            tick;
        end
        MemReady = 1'b1;
        MemInsn = 4'hB;
        tick;
        m_insn = 4'hB;
        check("nto_valid", 32'(InsnValid), 32'd1);
        check("nto_insn", 32'(Insn), 32'(m_insn));
        ack(1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
